// File: rtl/counter_pkg.sv
// Shared definitions for the multi-channel counter: bound-handling modes,
// per-channel action decode and the load clamp helper.
package counter_pkg;

  // Behaviour at the count bounds.
  localparam int unsigned MODE_WRAP     = 0;
  localparam int unsigned MODE_SATURATE = 1;

  // Winning action for one channel in one cycle (clear > load > step > hold).
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_STEP
  } chan_action_e;

  // Load values above the terminal value are silently pulled down to it.
  function automatic int unsigned clamp_to_limit(input int unsigned value,
                                                 input int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage : counter_pkg

// File: rtl/counter_channel.sv
// One up/down counter channel: count register plus sticky overflow and
// underflow flags, bounded to [0, LIMIT], wrapping or saturating at the bounds.
module counter_channel
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LIMIT    = 7,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ZERO_V  = '0;
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);
  localparam bit               SAT     = (SATURATE == MODE_SATURATE);

  chan_action_e     action;
  logic [WIDTH-1:0] count_d;
  logic             overflow_d;
  logic             underflow_d;

  // Pick the single winning action for this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    action = ACT_HOLD;
    if (clear)       action = ACT_CLEAR;
    else if (load)   action = ACT_LOAD;
    else if (enable) action = ACT_STEP;
  end

  // Next-state: flag_clr drops the flags first so a same-cycle event re-sets them.
  always_comb begin
    count_d     = count;
    overflow_d  = overflow & ~flag_clr;
    underflow_d = underflow & ~flag_clr;
    unique case (action)
      ACT_CLEAR: begin
        count_d     = ZERO_V;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      ACT_LOAD: begin
        count_d = WIDTH'(clamp_to_limit(32'(load_value), LIMIT));
      end
      ACT_STEP: begin
        if (!down) begin
          if (count == LIMIT_V) begin
            overflow_d = 1'b1;
            count_d    = SAT ? LIMIT_V : ZERO_V;
          end else begin
            count_d = count + ONE_V;
          end
        end else begin
          if (count == ZERO_V) begin
            underflow_d = 1'b1;
            count_d     = SAT ? ZERO_V : LIMIT_V;
          end else begin
            count_d = count - ONE_V;
          end
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      count     <= ZERO_V;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

  // Terminal-count decode straight from the register, no input path.
  assign at_limit = (count == LIMIT_V);

endmodule : counter_channel

// File: rtl/multi_channel_counter.sv
// CHANNELS independent bounded up/down counters on one clock, with packed
// per-channel buses and a global OR of all sticky flags.
module multi_channel_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned LIMIT    = 7,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       io_enable,
  input  logic [CHANNELS-1:0]       io_down,
  input  logic [CHANNELS-1:0]       io_load,
  input  logic [CHANNELS*WIDTH-1:0] io_load_value,
  input  logic [CHANNELS-1:0]       io_clear,
  input  logic [CHANNELS-1:0]       io_flag_clr,
  output logic [CHANNELS*WIDTH-1:0] io_count,
  output logic [CHANNELS-1:0]       io_at_limit,
  output logic [CHANNELS-1:0]       io_overflow,
  output logic [CHANNELS-1:0]       io_underflow,
  output logic                      io_any_flag
);

  // Reject parameter sets the channel logic cannot represent.
  if ((LIMIT == 0) || ((LIMIT >> WIDTH) != 0)) begin : g_bad_limit
    $fatal(1, "multi_channel_counter: LIMIT=%0d out of range for WIDTH=%0d", LIMIT, WIDTH);
  end
  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "multi_channel_counter: WIDTH=%0d must be at least 2", WIDTH);
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $fatal(1, "multi_channel_counter: CHANNELS must be at least 1");
  end

  // One channel instance per bus slice.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    counter_channel #(
      .WIDTH    (WIDTH),
      .LIMIT    (LIMIT),
      .SATURATE (SATURATE)
    ) u_channel (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (io_enable[ch]),
      .down       (io_down[ch]),
      .load       (io_load[ch]),
      .load_value (io_load_value[ch*WIDTH +: WIDTH]),
      .clear      (io_clear[ch]),
      .flag_clr   (io_flag_clr[ch]),
      .count      (io_count[ch*WIDTH +: WIDTH]),
      .at_limit   (io_at_limit[ch]),
      .overflow   (io_overflow[ch]),
      .underflow  (io_underflow[ch])
    );
  end

  // Summary flag for interrupt logic, built only from registered flags.
  assign io_any_flag = |(io_overflow | io_underflow);

endmodule : multi_channel_counter
